// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload periodic modes.
// IRQ is the pending flag gated by the CTRL interrupt mask; it feeds CP0 HWInt[2].
`timescale 1ns/1ps
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [1:0]  Add,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ADDR_CTRL   = 2'd0,
    ADDR_PRESET = 2'd1,
    ADDR_COUNT  = 2'd2,
    ADDR_NONE   = 2'd3
  } addr_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       enable;
  } ctrl_t;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  state_e      state;
  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic wr_ctrl;
  logic wr_preset;
  logic periodic;
  logic flag_set;
  logic flag_clr;

  always_comb begin
    wr_ctrl   = WE && (addr_e'(Add) == ADDR_CTRL);
    wr_preset = WE && (addr_e'(Add) == ADDR_PRESET);
    periodic  = (ctrl.mode == MODE_PERIODIC);
    // Expiry sets the flag; a same-edge CPU write must not swallow it.
    flag_set  = (state == CNT) && ctrl.enable && (count <= 32'd1);
    flag_clr  = wr_ctrl || wr_preset || ((state == INT) && periodic);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl.enable) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl.enable) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= '0;
            state <= INT;
          end
        end
        INT: begin
          state <= IDLE;
          if (!periodic) ctrl.enable <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // NOTE: the last non-blocking assignment in a block wins, which is how a
      // CPU CTRL write overrides the one-shot enable clear on the same edge.
      if (wr_ctrl)   ctrl   <= ctrl_t'(DIn[3:0]);
      if (wr_preset) preset <= DIn;

      if (flag_set)      irq_flag <= 1'b1;
      else if (flag_clr) irq_flag <= 1'b0;
    end
  end

  // NOTE: combinational outputs get a default first so no latch is inferred.
  always_comb begin
    DOut = '0;
    case (addr_e'(Add))
      ADDR_CTRL:   DOut = {28'd0, ctrl};
      ADDR_PRESET: DOut = preset;
      ADDR_COUNT:  DOut = count;
      default:     DOut = '0;
    endcase
  end

  assign IRQ = irq_flag & ctrl.im;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: a cycle-level reference model predicts every
// read and IRQ; a monitor pops and compares once per cycle.
`timescale 1ns/1ps
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [1:0]  Add;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .WE    (WE),
    .Add   (Add),
    .DIn   (DIn),
    .DOut  (DOut),
    .IRQ   (IRQ)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: a run is described by its phase, the value captured at load
  // and how many counting edges have elapsed since then.
  typedef enum int {M_OFF, M_LOADING, M_COUNTING, M_FIRED} phase_e;
  phase_e      phase;
  bit          m_en, m_im, m_flag;
  bit [1:0]    m_mode;
  bit [31:0]   m_preset, m_count;
  longint      loaded, ticks;

  function automatic void model_reset();
    phase = M_OFF; m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
    m_preset = 0; m_count = 0; loaded = 0; ticks = 0;
  endfunction

  function automatic void model_step(input logic we, input logic [1:0] add, input logic [31:0] din);
    phase_e nxt = phase;
    bit set_f = 0, clr_f = 0, kill_en = 0;
    longint eff;
    case (phase)
      M_OFF: if (m_en) nxt = M_LOADING;
      M_LOADING: begin
        loaded = m_preset; ticks = 0; m_count = m_preset; nxt = M_COUNTING;
      end
      M_COUNTING: begin
        eff = (loaded == 0) ? 1 : loaded;
        if (!m_en) nxt = M_OFF;
        else if (ticks + 1 < eff) begin ticks++; m_count = 32'(loaded - ticks); end
        else begin m_count = 0; set_f = 1; nxt = M_FIRED; end
      end
      M_FIRED: begin
        nxt = M_OFF;
        if (m_mode == 2'b01) clr_f = 1; else kill_en = 1;
      end
      default: nxt = M_OFF;
    endcase
    if (kill_en) m_en = 0;
    if (we && add == 2'd0) begin {m_im, m_mode, m_en} = din[3:0]; clr_f = 1; end
    if (we && add == 2'd1) begin m_preset = din; clr_f = 1; end
    if (set_f) m_flag = 1; else if (clr_f) m_flag = 0;
    phase = nxt;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] radd);
    case (radd)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct { logic [1:0] add; logic [31:0] dout; logic irq; } exp_t;
  exp_t sb[$];
  int   cyc = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("cyc%0d DOut[%0d]", cyc, e.add), DOut, e.dout);
        check($sformatf("cyc%0d IRQ", cyc), 32'(IRQ), 32'(e.irq));
      end
    end
  end

  // Entered and left at negedge+1: drive one bus op, let the edge happen,
  // then present a random read address and queue what it must return.
  task automatic cycle(input logic we, input logic [1:0] add, input logic [31:0] din);
    logic [1:0] radd;
    WE = we; Add = add; DIn = din;
    @(posedge clk);
    model_step(we, add, din);
    cyc++;
    #1;
    radd = 2'($urandom_range(0, 3));
    WE = 1'b0; Add = radd;
    sb.push_back('{add: radd, dout: model_read(radd), irq: m_flag & m_im});
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] add, input logic [31:0] din);
    cycle(1'b1, add, din);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0);
  endtask

  task automatic read_check(input string name, input logic [1:0] add, input logic [31:0] exp);
    Add = add;
    #1;
    check(name, DOut, exp);
  endtask

  logic [31:0] pmask;

  initial begin : stim
    reset = 1'b1; WE = 1'b0; Add = 2'd0; DIn = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    for (int a = 0; a < 4; a++) read_check("reset DOut", 2'(a), 32'd0);
    check("reset IRQ", 32'(IRQ), 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;

    // One-shot, PRESET=5: IRQ rises after E7 and holds
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    idle(6);
    check("oneshot IRQ before E7", 32'(IRQ), 32'd0);
    idle(1);
    check("oneshot IRQ at E7", 32'(IRQ), 32'd1);
    idle(1);
    read_check("oneshot CTRL after E8", 2'd0, 32'h8);
    idle(3);
    check("oneshot IRQ held", 32'(IRQ), 32'd1);
    wr(2'd0, 32'h8);
    check("oneshot IRQ cleared by CTRL write", 32'(IRQ), 32'd0);

    // Asynchronous reset while IRQ is high
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    idle(6);
    check("pre-reset IRQ", 32'(IRQ), 32'd1);
    reset = 1'b1;
    #1;
    check("async reset IRQ", 32'(IRQ), 32'd0);
    for (int a = 0; a < 4; a++) read_check("async reset DOut", 2'(a), 32'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clk); #1;

    // Periodic, PRESET=3: pulses after E5, E11, E17
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    pmask = 32'd0;
    for (int k = 1; k <= 17; k++) begin
      idle(1);
      pmask[k] = IRQ;
    end
    check("periodic pulse positions", pmask, 32'h0002_0820);
    wr(2'd0, 32'd0);
    idle(4);

    // Masked expiry, then clearing the flag keeps IRQ low
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    idle(8);
    check("masked IRQ", 32'(IRQ), 32'd0);
    wr(2'd0, 32'h8);
    idle(1);
    check("mask re-enabled after clear", 32'(IRQ), 32'd0);

    // Disable mid-count freezes COUNT; re-enable restarts from LOAD
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    idle(5);
    wr(2'd0, 32'h8);
    idle(3);
    read_check("frozen COUNT", 2'd2, 32'd6);
    wr(2'd0, 32'h9);
    idle(2);
    read_check("restart COUNT", 2'd2, 32'd10);
    wr(2'd0, 32'h8);
    idle(3);

    // PRESET=0 fires on the same schedule as PRESET=1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    idle(2);
    check("preset0 IRQ before E3", 32'(IRQ), 32'd0);
    idle(1);
    check("preset0 IRQ at E3", 32'(IRQ), 32'd1);
    wr(2'd0, 32'h0);
    idle(2);

    // Maximum preset decrements without wrapping
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h1);
    idle(4);
    read_check("max preset COUNT", 2'd2, 32'hFFFF_FFFD);
    wr(2'd0, 32'h0);
    idle(2);

    // Writes to COUNT and the unmapped slot change nothing
    wr(2'd2, 32'h1234);
    wr(2'd3, 32'hF);
    read_check("CTRL after ignored writes", 2'd0, 32'h0);
    read_check("COUNT after ignored writes", 2'd2, 32'hFFFF_FFFC);
    read_check("unmapped read", 2'd3, 32'h0);

    // PRESET written mid-count applies only at the next LOAD
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h1);
    idle(3);
    wr(2'd1, 32'd2);
    idle(1);
    read_check("running COUNT ignores new PRESET", 2'd2, 32'd3);
    idle(6);
    wr(2'd0, 32'h9);
    idle(2);
    read_check("new PRESET at next LOAD", 2'd2, 32'd2);
    wr(2'd0, 32'h0);
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      if ($urandom_range(0, 3) == 0) begin
        a = 2'($urandom_range(0, 3));
        d = $urandom;
        if (a == 2'd1 && $urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 8));
        wr(a, d);
      end else begin
        idle(1);
      end
    end
    idle(2);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
